// File: rtl/simt_control_unit_pkg.sv
// Shared types for the SIMT divergence controller: word, opcode, stack-entry kind and FSM state.
package simt_control_unit_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned OP_LSB = WORD_W - OP_W;

  typedef logic [WORD_W-1:0] word_t;

  // Vector opcodes sit at encodings the scalar ISA leaves unused.
  typedef enum logic [OP_W-1:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDI  = 6'h08,
    VBEQ  = 6'h1C,
    VBNE  = 6'h1D,
    VJOIN = 6'h1E,
    VSW   = 6'h1F,
    LW    = 6'h23,
    SW    = 6'h2B
  } opcode_t;

  typedef enum logic {RECONV = 1'b0, ELSE = 1'b1} stk_kind_t;
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} simt_state_t;

  function automatic logic is_vbranch(opcode_t op);
    return (op == VBEQ) || (op == VBNE);
  endfunction

endpackage

// File: rtl/simt_control_unit_if.sv
// Decoder-side bundle of the SIMT control unit: instruction/branch inputs, lane enables and redirect outputs.
interface simt_control_unit_if
  import simt_control_unit_pkg::*;
#(
  parameter int unsigned THREADS = 4,
  parameter int unsigned DEPTH   = 8
);
  localparam int unsigned PTR_W = $clog2(DEPTH + 1);

  word_t              instr;
  logic               instr_valid;
  logic               stall;
  word_t              npc;
  word_t              br_target;
  logic [THREADS-1:0] vzf;
  logic               dec_vregWEN;
  logic               dec_memWEN;

  logic [THREADS-1:0] active_mask;
  logic [THREADS-1:0] vregWEN;
  logic [THREADS-1:0] vmemWEN;
  logic               pc_redirect;
  word_t              redirect_pc;
  logic [PTR_W-1:0]   stack_ptr;
  logic               fault;

  modport master (
    output instr, instr_valid, stall, npc, br_target, vzf, dec_vregWEN, dec_memWEN,
    input  active_mask, vregWEN, vmemWEN, pc_redirect, redirect_pc, stack_ptr, fault
  );

  modport slave (
    input  instr, instr_valid, stall, npc, br_target, vzf, dec_vregWEN, dec_memWEN,
    output active_mask, vregWEN, vmemWEN, pc_redirect, redirect_pc, stack_ptr, fault
  );

endinterface

// File: rtl/simt_control_unit_reconv_stack.sv
// Reconvergence LIFO: pushes two entries (RECONV then ELSE) in one edge, pops one; caller guards bounds.
module simt_reconv_stack
  import simt_control_unit_pkg::*;
#(
  parameter int unsigned THREADS = 4,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push2,
  input  logic [THREADS+WORD_W:0]            push_reconv,
  input  logic [THREADS+WORD_W:0]            push_else,
  input  logic                               pop,
  output logic [THREADS+WORD_W:0]            top,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic [$clog2(DEPTH+1)-1:0]         free
);

  localparam int unsigned PTR_W   = $clog2(DEPTH + 1);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENTRY_W = THREADS + WORD_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   ptr;

  // Entry storage carries no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push2) begin
      mem[AW'(ptr)]              <= push_reconv;
      mem[AW'(ptr + PTR_W'(1))]  <= push_else;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (push2) begin
      ptr <= ptr + PTR_W'(2);
    end else if (pop) begin
      ptr <= ptr - PTR_W'(1);
    end
  end

  assign top   = mem[AW'(ptr - PTR_W'(1))];
  assign count = ptr;
  assign free  = PTR_W'(DEPTH) - ptr;

endmodule

// File: rtl/simt_control_unit.sv
// SIMT divergence controller: tracks the active lane mask through VBEQ/VBNE/VJOIN and masks vector write enables.
module simt_control_unit
  import simt_control_unit_pkg::*;
#(
  parameter int unsigned THREADS = 4,
  parameter int unsigned DEPTH   = 8
) (
  input logic               CLK,
  input logic               nRST,
  simt_control_unit_if.slave bus
);

  localparam int unsigned PTR_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = THREADS + WORD_W + 1;

  typedef struct packed {
    logic [THREADS-1:0] mask;
    word_t              pc;
    stk_kind_t          kind;
  } stk_entry_t;

  simt_state_t        state;
  logic [THREADS-1:0] mask_q;
  logic               redirect_q;
  word_t              redirect_pc_q;
  logic               fault_q;

  opcode_t            op;
  logic               accept;
  logic [THREADS-1:0] taken;
  logic               uni_taken;
  logic               divergent;
  logic               can_push;
  logic               do_push;
  logic               do_fault;
  logic               do_pop;
  logic [PTR_W-1:0]   count;
  logic [PTR_W-1:0]   free;
  stk_entry_t         entry_reconv;
  stk_entry_t         entry_else;
  logic [ENTRY_W-1:0] top_vec;
  stk_entry_t         top_e;
  logic               unused_instr_bits;

  assign unused_instr_bits = ^bus.instr[OP_LSB-1:0];

  // Decode and branch classification against the mask in force this cycle.
  assign op        = opcode_t'(bus.instr[WORD_W-1:OP_LSB]);
  assign accept    = bus.instr_valid & ~bus.stall & (state == RUN);
  assign taken     = mask_q & ((op == VBEQ) ? bus.vzf : ~bus.vzf);
  assign uni_taken = accept & is_vbranch(op) & (taken == mask_q);
  assign divergent = accept & is_vbranch(op) & (taken != mask_q) & (taken != '0);
  assign can_push  = free >= PTR_W'(2);
  assign do_push   = divergent & can_push;
  assign do_fault  = divergent & ~can_push;
  assign do_pop    = accept & (op == VJOIN) & (count != '0);

  assign entry_reconv = '{mask: mask_q,          pc: '0,         kind: RECONV};
  assign entry_else   = '{mask: mask_q & ~taken, pc: bus.npc,    kind: ELSE};
  assign top_e        = top_vec;

  simt_reconv_stack #(
    .THREADS (THREADS),
    .DEPTH   (DEPTH)
  ) u_stack (
    .clk         (CLK),
    .rst_n       (nRST),
    .push2       (do_push),
    .push_reconv (entry_reconv),
    .push_else   (entry_else),
    .pop         (do_pop),
    .top         (top_vec),
    .count       (count),
    .free        (free)
  );

  // Control FSM; pc_redirect self-clears every edge so it never stretches under stall.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= RUN;
      mask_q        <= '1;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      fault_q       <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state)
        RUN: begin
          if (uni_taken) begin
            redirect_q    <= 1'b1;
            redirect_pc_q <= bus.br_target;
          end else if (do_push) begin
            mask_q        <= taken;
            redirect_q    <= 1'b1;
            redirect_pc_q <= bus.br_target;
          end else if (do_fault) begin
            state   <= FAULT;
            fault_q <= 1'b1;
          end else if (do_pop) begin
            mask_q <= top_e.mask;
            if (top_e.kind == ELSE) begin
              redirect_q    <= 1'b1;
              redirect_pc_q <= top_e.pc;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

  assign bus.active_mask = mask_q;
  assign bus.pc_redirect = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.stack_ptr   = count;
  assign bus.fault       = fault_q;
  assign bus.vregWEN     = {THREADS{bus.dec_vregWEN & (state == RUN)}} & mask_q;
  assign bus.vmemWEN     = {THREADS{bus.dec_memWEN  & (state == RUN)}} & mask_q;

endmodule

// File: tb/tb_simt_control_unit.sv
// Bench for simt_control_unit: directed plan steps then random traffic against a queue-based lane-mask model.
module tb_simt_control_unit;
  import simt_control_unit_pkg::*;

  logic CLK = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  simt_control_unit_if #(.THREADS(4), .DEPTH(8)) bus_a ();
  simt_control_unit_if #(.THREADS(4), .DEPTH(2)) bus_b ();

  simt_control_unit #(.THREADS(4), .DEPTH(8)) dut_a (.CLK(CLK), .nRST(rst_a_n), .bus(bus_a));
  simt_control_unit #(.THREADS(4), .DEPTH(2)) dut_b (.CLK(CLK), .nRST(rst_b_n), .bus(bus_b));

  typedef struct {
    logic [3:0] mask;
    word_t      pc;
    bit         is_else;
  } mentry_t;

  mentry_t    m_q[$];
  logic [3:0] m_mask;
  logic       m_red;
  word_t      m_rpc;
  logic       m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mask  = 4'hF;
    m_red   = 1'b0;
    m_rpc   = '0;
    m_fault = 1'b0;
  endtask

  // Lane-level rules: branches split the mask, joins restore the most recent saved mask.
  task automatic model_step(input logic [5:0] op, input logic v, input logic st,
                            input logic [3:0] z, input word_t n, input word_t t);
    logic [3:0] tk;
    mentry_t    e;
    m_red = 1'b0;
    if (v && !st && !m_fault) begin
      if (op == 6'(VBEQ) || op == 6'(VBNE)) begin
        tk = m_mask & ((op == 6'(VBEQ)) ? z : ~z);
        if (tk == m_mask) begin
          m_red = 1'b1; m_rpc = t;
        end else if (tk != 4'h0) begin
          if (8 - m_q.size() >= 2) begin
            m_q.push_back('{mask: m_mask, pc: 32'h0, is_else: 1'b0});
            m_q.push_back('{mask: m_mask & ~tk, pc: n, is_else: 1'b1});
            m_mask = tk; m_red = 1'b1; m_rpc = t;
          end else begin
            m_fault = 1'b1;
          end
        end
      end else if (op == 6'(VJOIN) && m_q.size() > 0) begin
        e = m_q.pop_back();
        m_mask = e.mask;
        if (e.is_else) begin
          m_red = 1'b1; m_rpc = e.pc;
        end
      end
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".mask"},  32'(bus_a.active_mask), 32'(m_mask));
    chk({tag, ".sp"},    32'(bus_a.stack_ptr),   32'(m_q.size()));
    chk({tag, ".red"},   32'(bus_a.pc_redirect), 32'(m_red));
    chk({tag, ".fault"}, 32'(bus_a.fault),       32'(m_fault));
    if (m_red) chk({tag, ".rpc"}, bus_a.redirect_pc, m_rpc);
  endtask

  // One clock on dut_a: drive at negedge, check lane enables, clock, check registered state.
  task automatic cycle(input string tag, input logic [5:0] op, input logic v, input logic st,
                       input logic [3:0] z, input word_t n, input word_t t,
                       input logic rw, input logic mw);
    bus_a.instr       = {op, 26'($urandom)};
    bus_a.instr_valid = v;
    bus_a.stall       = st;
    bus_a.vzf         = z;
    bus_a.npc         = n;
    bus_a.br_target   = t;
    bus_a.dec_vregWEN = rw;
    bus_a.dec_memWEN  = mw;
    #1;
    chk({tag, ".vreg"}, 32'(bus_a.vregWEN), 32'((rw && !m_fault) ? m_mask : 4'h0));
    chk({tag, ".vmem"}, 32'(bus_a.vmemWEN), 32'((mw && !m_fault) ? m_mask : 4'h0));
    model_step(op, v, st, z, n, t);
    @(negedge CLK);
    check_regs(tag);
  endtask

  task automatic reset_a(input string tag);
    bus_a.instr_valid = 1'b0;
    #2 rst_a_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".mask"},  32'(bus_a.active_mask), 32'hF);
    chk({tag, ".sp"},    32'(bus_a.stack_ptr),   32'h0);
    chk({tag, ".red"},   32'(bus_a.pc_redirect), 32'h0);
    chk({tag, ".rpc"},   bus_a.redirect_pc,      32'h0);
    chk({tag, ".fault"}, 32'(bus_a.fault),       32'h0);
    @(negedge CLK);
    rst_a_n = 1'b1;
  endtask

  task automatic cycle_b(input logic [5:0] op, input logic [3:0] z, input logic rw);
    bus_b.instr       = {op, 26'h0};
    bus_b.instr_valid = 1'b1;
    bus_b.vzf         = z;
    bus_b.npc         = 32'h104;
    bus_b.br_target   = 32'h200;
    bus_b.dec_vregWEN = rw;
    @(negedge CLK);
  endtask

  initial begin
    logic [5:0] rop;
    int         r;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.instr = '0; bus_a.instr_valid = 1'b0; bus_a.stall = 1'b0; bus_a.vzf = '0;
    bus_a.npc = '0; bus_a.br_target = '0; bus_a.dec_vregWEN = 1'b0; bus_a.dec_memWEN = 1'b0;
    bus_b.instr = '0; bus_b.instr_valid = 1'b0; bus_b.stall = 1'b0; bus_b.vzf = '0;
    bus_b.npc = '0; bus_b.br_target = '0; bus_b.dec_vregWEN = 1'b0; bus_b.dec_memWEN = 1'b0;
    @(negedge CLK);
    reset_a("reset");

    // Uniform taken: full enables, redirect, no push.
    cycle("uni", 6'(VBEQ), 1, 0, 4'b1111, 32'h104, 32'h200, 1, 0);
    chk("uni.rpc_const", bus_a.redirect_pc, 32'h200);

    // Divergence then two joins.
    cycle("div", 6'(VBEQ), 1, 0, 4'b0011, 32'h104, 32'h200, 1, 1);
    chk("div.mask_const", 32'(bus_a.active_mask), 32'h3);
    chk("div.sp_const", 32'(bus_a.stack_ptr), 32'h2);
    cycle("join1", 6'(VJOIN), 1, 0, 4'h0, 32'h0, 32'h0, 1, 0);
    chk("join1.mask_const", 32'(bus_a.active_mask), 32'hC);
    chk("join1.rpc_const", bus_a.redirect_pc, 32'h104);
    cycle("join2", 6'(VJOIN), 1, 0, 4'h0, 32'h0, 32'h0, 0, 1);
    chk("join2.red_const", 32'(bus_a.pc_redirect), 32'h0);

    // Nested divergence unwinds in LIFO order.
    cycle("nest0", 6'(VBEQ), 1, 0, 4'b0011, 32'h104, 32'h200, 0, 0);
    cycle("nest1", 6'(VBEQ), 1, 0, 4'b0001, 32'h300, 32'h400, 1, 0);
    chk("nest1.sp_const", 32'(bus_a.stack_ptr), 32'h4);
    for (int i = 0; i < 4; i++) cycle("nestjoin", 6'(VJOIN), 1, 0, 4'h0, 32'h0, 32'h0, 1, 1);
    chk("nest.final_mask", 32'(bus_a.active_mask), 32'hF);

    // Stall freezes acceptance; redirect pulse drops even when stall rises.
    cycle("stall", 6'(VBNE), 1, 1, 4'b0101, 32'h500, 32'h600, 1, 0);
    cycle("unstall", 6'(VBNE), 1, 0, 4'b0101, 32'h500, 32'h600, 1, 0);
    chk("unstall.mask_const", 32'(bus_a.active_mask), 32'hA);
    cycle("stall_red", 6'(RTYPE), 1, 1, 4'h0, 32'h0, 32'h0, 1, 0);
    cycle("j1", 6'(VJOIN), 1, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    cycle("j2", 6'(VJOIN), 1, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    cycle("jempty", 6'(VJOIN), 1, 0, 4'h0, 32'h0, 32'h0, 0, 0);

    // Reset mid-divergence.
    cycle("prerst", 6'(VBEQ), 1, 0, 4'b0011, 32'h104, 32'h200, 0, 0);
    reset_a("midrst");

    // Shallow stack: second divergence overflows into FAULT.
    rst_b_n = 1'b1;
    cycle_b(6'(VBEQ), 4'b0011, 0);
    chk("b.div.mask", 32'(bus_b.active_mask), 32'h3);
    chk("b.div.sp", 32'(bus_b.stack_ptr), 32'h2);
    cycle_b(6'(VBEQ), 4'b0001, 0);
    chk("b.ovf.fault", 32'(bus_b.fault), 32'h1);
    chk("b.ovf.mask", 32'(bus_b.active_mask), 32'h3);
    chk("b.ovf.sp", 32'(bus_b.stack_ptr), 32'h2);
    bus_b.instr = {6'(RTYPE), 26'h20}; bus_b.dec_vregWEN = 1'b1; bus_b.dec_memWEN = 1'b1;
    #1;
    chk("b.add.vreg", 32'(bus_b.vregWEN), 32'h0);
    chk("b.add.vmem", 32'(bus_b.vmemWEN), 32'h0);
    @(negedge CLK);
    cycle_b(6'(VJOIN), 4'h0, 1);
    chk("b.join.sp", 32'(bus_b.stack_ptr), 32'h2);
    chk("b.join.fault", 32'(bus_b.fault), 32'h1);
    bus_b.instr_valid = 1'b0;
    #2 rst_b_n = 1'b0;
    #1;
    chk("b.rst.fault", 32'(bus_b.fault), 32'h0);
    chk("b.rst.mask", 32'(bus_b.active_mask), 32'hF);
    chk("b.rst.sp", 32'(bus_b.stack_ptr), 32'h0);
    @(negedge CLK);
    rst_b_n = 1'b1;
    reset_a("prerand");

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: rop = 6'(VBEQ);
        3, 4:    rop = 6'(VBNE);
        5, 6, 7: rop = 6'(VJOIN);
        8:       rop = 6'(RTYPE);
        default: rop = 6'(VSW);
      endcase
      cycle("rand", rop, ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
            4'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 59) == 0 || (m_fault && $urandom_range(0, 3) == 0))
        reset_a("randrst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
